serum_reg_slave: RTL and testbench
==================================

# serum_reg_slave

Serial register slave that sits directly downstream of the serum master wrapper and consumes the frames it drives on the serial link. It deserializes write and read commands (8-bit address, 32-bit data) and holds a bank of `NREGS` 32-bit registers. Read data is serialized back to the master, which captures it into its `so_data` result. All logic runs on the master's `clk`.

## Interface
- `DWIDTH`, 32, data word width
- `AWIDTH`, 8, address width
- `NREGS`, 16, register count; power of two, at most 2^AWIDTH
- `BASE`, 'hF, value of the address bits above the index field (`addr[AWIDTH-1:log2(NREGS)]`) that selects this slave

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `nreset`  in  1  asynchronous, active-low reset
- `cs_n`  in  1  frame select from master, active low
- `sdi`  in  1  serial data from master, MSB first
- `sdo`  out  1  serial read data to master, MSB first
- `sdo_oe`  out  1  high while `sdo` carries valid read data
- `busy`  out  1  high while a frame is in progress (state not IDLE)
- `wr_pulse`  out  1  one-cycle strobe on register commit
- `wr_index`  out  log2(NREGS)  register index written, valid with `wr_pulse`
- `frame_err`  out  1  one-cycle strobe: aborted frame or out-of-range access
- `regs_o`  out  NREGS*DWIDTH  flat register bank; reg i at `[i*DWIDTH +: DWIDTH]`

## Operation
- Frame layout, one bit per `clk` while `cs_n`=0:
  - RW bit (1=write, 0=read)
  - AWIDTH address bits
  - write frames: DWIDTH data bits on `sdi`
  - read frames: 1 turnaround cycle, then DWIDTH bits on `sdo`
- States:
  - IDLE: `cs_n`=0 sampled → CMD-bit captured that edge → ADDR
  - ADDR: AWIDTH bits shifted in; after the last bit → WDATA (write) or TURN (read)
  - WDATA: DWIDTH bits; after the last bit → COMMIT
  - COMMIT: one cycle; register updated and `wr_pulse` asserted if in range → DONE
  - TURN: one cycle; selected register loaded into the output shift register → RDATA
  - RDATA: DWIDTH cycles driving `sdo` → DONE
  - DONE: `sdi` ignored until `cs_n`=1 → IDLE
- Address is in range iff upper address bits == `BASE`. Index = low log2(NREGS) bits.
- Out-of-range write: no register change, no `wr_pulse`, `frame_err` pulses in the COMMIT cycle.
- Out-of-range read: `sdo` shifts all zeros, `frame_err` pulses in the TURN cycle.
- `cs_n`=1 in any state other than IDLE or DONE aborts the frame:
  - next state is IDLE
  - no register write
  - `frame_err` pulses for one cycle
  - `sdo_oe` drops on the next edge
- `cs_n` must be high for at least one cycle between frames. Back-to-back frames require a return to IDLE.
- Reset (asynchronous, any state) values:
  - state = IDLE
  - all registers = 0
  - `sdo`=0, `sdo_oe`=0, `busy`=0, `wr_pulse`=0, `wr_index`=0, `frame_err`=0
  - a frame in flight is discarded

## Timing
- Edge E0 is the first edge with `cs_n`=0; `sdi` at E0 is the RW bit.
- Address bits are sampled at E1..E8.
- Write path:
  - data bits are sampled at E9..E40
  - COMMIT is the cycle after E40
  - the register and `regs_o` show the new value from E42
  - `wr_pulse` is high between E41 and E42
  - write latency from the last data bit is 2 edges
- Read path:
  - TURN follows E8
  - bit DWIDTH-1 is valid on `sdo` after E10 with `sdo_oe`=1
  - bit 0 is valid after E41
  - `sdo_oe` falls at E42
- `sdo` and `sdo_oe` are registered outputs; no combinational path from `sdi`/`cs_n`.
- `busy` rises at E0 and falls on the edge that samples `cs_n`=1 in DONE.

## Test plan
- Reset: hold `nreset`=0 4 cycles, release → all outputs 0, all `regs_o` words 0.
- Write 0xF3 ← 0xB4B4B4B4 → `wr_pulse` once with `wr_index`=3; reg 3 = 0xB4B4B4B4; others unchanged.
- Read 0xF3 after that write → `sdo` shifts 0xB4B4B4B4 MSB first over 32 cycles after TURN; `sdo_oe` high exactly 32 cycles.
- Write 0x23 ← 0x12345678 (out of range) → `frame_err` pulse, no `wr_pulse`, reg 3 still 0xB4B4B4B4. Read 0x23 → 32 zero bits, `frame_err` pulse.
- Abort: raise `cs_n` after 20 data bits of write 0xF5 ← 0xFFFFFFFF → `frame_err` pulse, reg 5 stays 0, IDLE next cycle. The following full write 0xF5 ← 0x1 succeeds.
- Async reset mid-read of 0xF3 at bit 10 → `sdo_oe` low immediately. After release, `busy`=0 and reg 3 = 0.

Source files
------------

// File: rtl/serum_reg_slave.sv
// serum_reg_slave
// Serial register slave for the serum master. It receives frames one bit
// per clk while cs_n is low: an RW bit, an AWIDTH-bit address, then either
// DWIDTH write-data bits on sdi, or one turnaround cycle followed by
// DWIDTH read-data bits on sdo.
//
// Ports:
//   clk        system clock, rising edge
//   nreset     asynchronous active-low reset
//   cs_n       frame select, active low
//   sdi        serial data in, MSB first
//   sdo        serial read data out, MSB first (registered)
//   sdo_oe     high while sdo carries read data (registered)
//   busy       high while a frame is in progress
//   wr_pulse   one-cycle strobe when a register is committed
//   wr_index   index of the register written, valid with wr_pulse
//   frame_err  one-cycle strobe on abort or out-of-range access
//   regs_o     flat register bank, reg i at [i*DWIDTH +: DWIDTH]
module serum_reg_slave #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int NREGS  = 16,
    parameter int BASE   = 'hF
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          cs_n,
    input  logic                          sdi,
    output logic                          sdo,
    output logic                          sdo_oe,
    output logic                          busy,
    output logic                          wr_pulse,
    output logic [$clog2(NREGS)-1:0]      wr_index,
    output logic                          frame_err,
    output logic [NREGS*DWIDTH-1:0]       regs_o
);

    localparam int IW = $clog2(NREGS);
    localparam int CW = $clog2((DWIDTH > AWIDTH) ? DWIDTH : AWIDTH);
    localparam logic [AWIDTH-IW-1:0] BASE_BITS = (AWIDTH-IW)'(BASE);
    localparam logic [CW-1:0] ALAST = CW'(AWIDTH - 1);
    localparam logic [CW-1:0] DLAST = CW'(DWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, COMMIT, TURN, RDATA, DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_abort;
    logic [CW-1:0]             r_cnt;
    logic                      r_isWrite;
    logic                      r_inRange;
    logic [AWIDTH-1:0]         r_addr;
    logic [AWIDTH-1:0]         w_addrNext;
    logic                      w_addrInRange;
    logic [DWIDTH-1:0]         r_shift;
    logic [DWIDTH-1:0]         r_wrData;
    logic [DWIDTH-1:0]         w_rdWord;
    logic [NREGS*DWIDTH-1:0]   r_bank;

    assign busy          = (r_state != IDLE);
    assign regs_o        = r_bank;
    assign w_addrNext    = {r_addr[AWIDTH-2:0], sdi};
    // The range decision is made on the edge that shifts in the last address
    // bit, so it must look at the address including the incoming bit.
    assign w_addrInRange = (w_addrNext[AWIDTH-1:IW] == BASE_BITS);

    // Read mux: the register selected by the captured index.
    always_comb begin
        w_rdWord = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (r_addr[IW-1:0] == IW'(i)) begin
                w_rdWord = r_bank[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Deselecting the slave anywhere mid-frame aborts
    // back to IDLE; in DONE it is the normal end of frame.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            IDLE:   if (!cs_n) w_next = ADDR;
            ADDR: begin
                if (cs_n) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (r_cnt == ALAST) begin
                    w_next = r_isWrite ? WDATA : TURN;
                end
            end
            WDATA: begin
                if (cs_n) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (r_cnt == DLAST) begin
                    w_next = COMMIT;
                end
            end
            COMMIT, TURN: begin
                if (cs_n) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else begin
                    w_next = (r_state == COMMIT) ? DONE : RDATA;
                end
            end
            RDATA: begin
                if (cs_n) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (r_cnt == DLAST) begin
                    w_next = DONE;
                end
            end
            DONE:   if (cs_n) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath. The bit counter restarts whenever the state changes, so each
    // shifting state counts its own bits from zero. A commit is staged in
    // r_wrData on the COMMIT edge (raising wr_pulse) and lands in the bank on
    // the following edge, which keeps wr_pulse and the bank update aligned.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt     <= '0;
            r_isWrite <= 1'b0;
            r_inRange <= 1'b0;
            r_addr    <= '0;
            r_shift   <= '0;
            r_wrData  <= '0;
            r_bank    <= '0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_index  <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;

            if (r_state != w_next) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (!cs_n) r_isWrite <= sdi;
                end
                ADDR: begin
                    if (!cs_n) begin
                        r_addr <= w_addrNext;
                        if (r_cnt == ALAST) begin
                            r_inRange <= w_addrInRange;
                            if (!r_isWrite && !w_addrInRange) frame_err <= 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (!cs_n) begin
                        r_shift <= {r_shift[DWIDTH-2:0], sdi};
                        if (r_cnt == DLAST && !r_inRange) frame_err <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (!cs_n && r_inRange) begin
                        wr_pulse <= 1'b1;
                        wr_index <= r_addr[IW-1:0];
                        r_wrData <= r_shift;
                    end
                end
                TURN: begin
                    if (!cs_n) r_shift <= r_inRange ? w_rdWord : '0;
                end
                RDATA: begin
                    if (!cs_n) r_shift <= {r_shift[DWIDTH-2:0], 1'b0};
                end
                default: ;
            endcase

            if (w_abort) frame_err <= 1'b1;

            sdo_oe <= (r_state == RDATA) && !cs_n;
            sdo    <= ((r_state == RDATA) && !cs_n) ? r_shift[DWIDTH-1] : 1'b0;

            for (int i = 0; i < NREGS; i++) begin
                if (wr_pulse && wr_index == IW'(i)) begin
                    r_bank[i*DWIDTH +: DWIDTH] <= r_wrData;
                end
            end
        end
    end

endmodule

// File: tb/tb_serum_reg_slave.sv
// tb_serum_reg_slave
// Self-checking bench for serum_reg_slave. Frames are driven on the falling
// edge; expected read words and write indices are queued when a frame is
// driven and popped by a falling-edge monitor when the DUT produces them.
module tb_serum_reg_slave;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          cs_n = 1'b1;
    logic          sdi = 1'b0;
    logic          sdo;
    logic          sdo_oe;
    logic          busy;
    logic          wr_pulse;
    logic [3:0]    wr_index;
    logic          frame_err;
    logic [511:0]  regs_o;

    int            checkCount = 0;
    int            errorCount = 0;
    logic [31:0]   expRegs [16];
    logic [31:0]   rdQ [$];
    logic [3:0]    wrQ [$];
    int            expErr = 0;
    int            errCycles = 0;
    int            expWr = 0;
    int            wrSeen = 0;
    logic [31:0]   rdWord = '0;
    int            rdBits = 0;
    int            oeRun = 0;
    logic          prevOe = 1'b0;

    serum_reg_slave dut (
        .clk       (clk),
        .nreset    (nreset),
        .cs_n      (cs_n),
        .sdi       (sdi),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .busy      (busy),
        .wr_pulse  (wr_pulse),
        .wr_index  (wr_index),
        .frame_err (frame_err),
        .regs_o    (regs_o)
    );

    always #5 clk = ~clk;

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
        end
    endtask

    // Compare the whole register bank against the model.
    task automatic compareBank(input string tag);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("%s_reg%0d", tag, i), regs_o[i*32 +: 32], expRegs[i]);
        end
    endtask

    // Drive one frame and update the model/scoreboard. abortAfter >= 0 raises
    // cs_n after that many write-data bits.
    task automatic applyStimulus(input bit isWrite, input logic [7:0] addr,
                                 input logic [31:0] data, input int abortAfter);
        bit inRange;
        inRange = (addr[7:4] == 4'hF);
        if (abortAfter >= 0) begin
            expErr++;
        end else if (isWrite) begin
            if (inRange) begin
                wrQ.push_back(addr[3:0]);
                expRegs[addr[3:0]] = data;
                expWr++;
            end else begin
                expErr++;
            end
        end else begin
            rdQ.push_back(inRange ? expRegs[addr[3:0]] : 32'h0);
            if (!inRange) expErr++;
        end

        @(negedge clk);
        cs_n = 1'b0;
        sdi  = isWrite;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            sdi = addr[i];
        end
        if (isWrite) begin
            for (int k = 0; k < 32; k++) begin
                if (abortAfter == k) begin
                    @(negedge clk);
                    cs_n = 1'b1;
                    sdi  = 1'b0;
                    @(negedge clk);
                    checkOutput("abort_idle_busy", busy, 1'b0);
                    repeat (2) @(negedge clk);
                    return;
                end
                @(negedge clk);
                sdi = data[31-k];
            end
            @(negedge clk);
            sdi = 1'b0;
        end else begin
            repeat (33) begin
                @(negedge clk);
                sdi = 1'b0;
            end
        end
        @(negedge clk);
        cs_n = 1'b1;
        sdi  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: assembles read words, checks sdo_oe run length and write
    // strobes, and counts frame_err cycles.
    always @(negedge clk) begin
        if (!nreset) begin
            rdBits = 0;
            oeRun  = 0;
            prevOe = 1'b0;
        end else begin
            if (sdo_oe) begin
                rdWord = {rdWord[30:0], sdo};
                rdBits++;
                oeRun++;
                if (rdBits == 32) begin
                    rdBits = 0;
                    if (rdQ.size() == 0) checkOutput("rd_queue_underflow", 32'd1, 32'd0);
                    else checkOutput("rd_data", rdWord, rdQ.pop_front());
                end
            end else if (prevOe) begin
                checkOutput("sdo_oe_len", oeRun, 32);
                oeRun  = 0;
                rdBits = 0;
            end
            prevOe = sdo_oe;
            if (wr_pulse) begin
                wrSeen++;
                if (wrQ.size() == 0) checkOutput("wr_queue_underflow", 32'd1, 32'd0);
                else checkOutput("wr_index", 32'(wr_index), 32'(wrQ.pop_front()));
            end
            if (frame_err) errCycles++;
        end
    end

    // Main sequence.
    initial begin
        logic [3:0]  rIdx;
        logic [31:0] rData;
        for (int i = 0; i < 16; i++) expRegs[i] = '0;

        repeat (4) @(negedge clk);
        #2 nreset = 1'b1;
        @(negedge clk);
        checkOutput("rst_sdo", sdo, 1'b0);
        checkOutput("rst_sdo_oe", sdo_oe, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wr_pulse", wr_pulse, 1'b0);
        checkOutput("rst_wr_index", 32'(wr_index), 32'd0);
        checkOutput("rst_frame_err", frame_err, 1'b0);
        compareBank("rst");

        applyStimulus(1'b1, 8'hF3, 32'hB4B4_B4B4, -1);
        checkOutput("w1_wr_count", wrSeen, expWr);
        compareBank("w1");

        applyStimulus(1'b0, 8'hF3, 32'h0, -1);
        checkOutput("r1_err_count", errCycles, expErr);

        applyStimulus(1'b1, 8'h23, 32'h1234_5678, -1);
        checkOutput("w_oor_err_count", errCycles, expErr);
        checkOutput("w_oor_wr_count", wrSeen, expWr);
        compareBank("w_oor");

        applyStimulus(1'b0, 8'h23, 32'h0, -1);
        checkOutput("r_oor_err_count", errCycles, expErr);

        applyStimulus(1'b1, 8'hF5, 32'hFFFF_FFFF, 20);
        checkOutput("abort_err_count", errCycles, expErr);
        checkOutput("abort_wr_count", wrSeen, expWr);
        compareBank("abort");

        applyStimulus(1'b1, 8'hF5, 32'h0000_0001, -1);
        checkOutput("w5_wr_count", wrSeen, expWr);
        compareBank("w5");

        for (int r = 0; r < 4; r++) begin
            rIdx  = 4'($urandom_range(0, 15));
            rData = $urandom;
            applyStimulus(1'b1, {4'hF, rIdx}, rData, -1);
            applyStimulus(1'b0, {4'hF, rIdx}, 32'h0, -1);
        end
        applyStimulus(1'b0, 8'hF3, 32'h0, -1);
        compareBank("rand");
        checkOutput("rand_wr_count", wrSeen, expWr);
        checkOutput("rand_err_count", errCycles, expErr);

        // Asynchronous reset in the middle of a read of 0xF3.
        @(negedge clk);
        cs_n = 1'b0;
        sdi  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            sdi = (8'hF3 >> i) & 8'h01;
        end
        repeat (12) begin
            @(negedge clk);
            sdi = 1'b0;
        end
        checkOutput("mid_read_oe", sdo_oe, 1'b1);
        #2 nreset = 1'b0;
        #1;
        checkOutput("areset_sdo_oe", sdo_oe, 1'b0);
        checkOutput("areset_busy", busy, 1'b0);
        cs_n = 1'b1;
        for (int i = 0; i < 16; i++) expRegs[i] = '0;
        repeat (2) @(negedge clk);
        #2 nreset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", busy, 1'b0);
        checkOutput("post_rst_reg3", regs_o[3*32 +: 32], 32'h0);
        compareBank("post_rst");

        checkOutput("rdq_drained", rdQ.size(), 0);
        checkOutput("wrq_drained", wrQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
